// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a bouncy push-button pin and turns it into a
// debounced level plus single-cycle press/release events, with optional
// hold-to-auto-repeat.
module button_debouncer #(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic rpt_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // Terminal timer values. The sample that leaves IDLE/PRESSED counts as the
    // first debounce sample, so debounce completes one count earlier.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             PIN_IDLE  = ACTIVE_LOW;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             btn_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             long_nxt;

    // Two-flop synchronizer; resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2 ^ ACTIVE_LOW;

    // State, timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

    // Next-state, timer and output decode; a release sample always beats a timer expiry.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    timer_nxt = '0;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer == DEB_LAST) begin
                    state_nxt = PRESSED;
                    timer_nxt = '0;
                    press_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (!rpt_en) begin
                    timer_nxt = '0;
                end else if (timer == HOLD_LAST) begin
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                    press_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end

            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (!rpt_en) begin
                    state_nxt = PRESSED;
                    timer_nxt = '0;
                end else if (timer == RPT_LAST) begin
                    timer_nxt = '0;
                    press_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    timer_nxt = '0;
                end else if (timer == DEB_LAST) begin
                    state_nxt   = IDLE;
                    timer_nxt   = '0;
                    release_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase

        level_nxt = (state_nxt == PRESSED) || (state_nxt == REPEAT) ||
                    (state_nxt == RELEASE_WAIT);
        long_nxt  = (state_nxt == REPEAT);
    end

endmodule
